// File: rtl/ble_packet_tx_if.sv
// PDU byte stream from the link-layer controller into the BLE packet transmitter.
interface ble_packet_tx_if;
    logic [7:0] pdu_data;
    logic       pdu_valid;
    logic       pdu_ready;

    modport master (output pdu_data, output pdu_valid, input pdu_ready);
    modport slave  (input pdu_data, input pdu_valid, output pdu_ready);
endinterface

// File: rtl/ble_packet_tx.sv
// Bit-serial BLE 1 Mbps packet transmitter: preamble, access address, whitened PDU and CRC24,
// one symbol per CLKS_PER_SYM clocks towards the FSK modulator.
module ble_packet_tx #(
    parameter int          CLKS_PER_SYM  = 16,
    parameter int          PDU_MAX_BYTES = 39,
    parameter logic [23:0] CRC_POLY      = 24'h00065B,
    parameter logic [23:0] CRC_INIT      = 24'h555555
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [31:0]           acc_addr,
    input  logic [5:0]            channel,
    input  logic [5:0]            pdu_len,
    input  logic                  whiten_en,
    ble_packet_tx_if.slave        pduIf,
    output logic                  tx_bit,
    output logic                  sym_stb,
    output logic                  tx_active,
    output logic                  tx_done,
    output logic                  tx_err
);
    localparam int               SCW      = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
    localparam logic [SCW-1:0]   SYM_LAST = SCW'(CLKS_PER_SYM - 1);
    localparam logic [6:0]       MAX_LEN  = 7'(PDU_MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_AA,
        S_PDU,
        S_CRC
    } state_e;

    state_e         state_q, state_d;
    logic [SCW-1:0] symCnt_q, symCnt_d;
    logic [8:0]     symIdx_q, symIdx_d;
    logic [31:0]    accAddr_q, accAddr_d;
    logic [5:0]     pduLen_q, pduLen_d;
    logic           whitenEn_q, whitenEn_d;
    logic [7:0]     hold_q, hold_d;
    logic           holdFull_q, holdFull_d;
    logic [5:0]     fetched_q, fetched_d;
    logic [7:0]     shift_q, shift_d;
    logic [23:0]    crc_q, crc_d;
    logic [6:0]     lfsr_q, lfsr_d;
    logic           txBit_q, txBit_d;
    logic           symStb_q, symStb_d;
    logic           txActive_q, txActive_d;
    logic           txDone_q, txDone_d;
    logic           txErr_q, txErr_d;

    logic           pduReady;
    logic           lenOk;
    logic [8:0]     pduLast;
    logic           whiteBit;
    logic           needByte;
    logic           shiftBit;
    logic           crcSym;
    logic           emitPdu;
    logic           rawBit;
    logic [4:0]     crcSel;

    // Whitening LFSR step: p0<=p6, p4<=p3^p6, all other taps shift up by one.
    function automatic logic [6:0] lfsrStep(input logic [6:0] p);
        logic [6:0] n;
        n[0] = p[6];
        n[1] = p[0];
        n[2] = p[1];
        n[3] = p[2];
        n[4] = p[3] ^ p[6];
        n[5] = p[4];
        n[6] = p[5];
        return n;
    endfunction

    function automatic logic [23:0] crcStep(input logic [23:0] c, input logic d);
        logic fb;
        fb = c[23] ^ d;
        return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
    endfunction

    assign lenOk    = ({1'b0, pdu_len} >= 7'd2) && ({1'b0, pdu_len} <= MAX_LEN);
    assign pduLast  = {pduLen_q, 3'b000} - 9'd1;
    assign whiteBit = whitenEn_q & lfsr_q[6];
    assign pduReady = (state_q != S_IDLE) && !holdFull_q && (fetched_q < pduLen_q);

    assign pduIf.pdu_ready = pduReady;
    assign tx_bit          = txBit_q;
    assign sym_stb         = symStb_q;
    assign tx_active       = txActive_q;
    assign tx_done         = txDone_q;
    assign tx_err          = txErr_q;

    always_comb begin
        state_d    = state_q;
        symCnt_d   = symCnt_q;
        symIdx_d   = symIdx_q;
        accAddr_d  = accAddr_q;
        pduLen_d   = pduLen_q;
        whitenEn_d = whitenEn_q;
        hold_d     = hold_q;
        holdFull_d = holdFull_q;
        fetched_d  = fetched_q;
        shift_d    = shift_q;
        crc_d      = crc_q;
        lfsr_d     = lfsr_q;
        txBit_d    = txBit_q;
        symStb_d   = 1'b0;
        txActive_d = txActive_q;
        txDone_d   = 1'b0;
        txErr_d    = 1'b0;
        needByte   = 1'b0;
        shiftBit   = 1'b0;
        crcSym     = 1'b0;
        emitPdu    = 1'b0;
        rawBit     = 1'b0;
        crcSel     = 5'd0;

        if (pduIf.pdu_valid && pduReady) begin
            hold_d     = pduIf.pdu_data;
            holdFull_d = 1'b1;
            fetched_d  = fetched_q + 6'd1;
        end

        if (state_q == S_IDLE) begin
            txBit_d    = 1'b0;
            txActive_d = 1'b0;
            if (tx_start) begin
                if (lenOk) begin
                    state_d    = S_PRE;
                    symCnt_d   = '0;
                    symIdx_d   = 9'd0;
                    accAddr_d  = acc_addr;
                    pduLen_d   = pdu_len;
                    whitenEn_d = whiten_en;
                    holdFull_d = 1'b0;
                    fetched_d  = 6'd0;
                    crc_d      = CRC_INIT;
                    lfsr_d     = {channel[0], channel[1], channel[2],
                                  channel[3], channel[4], channel[5], 1'b1};
                    txActive_d = 1'b1;
                    symStb_d   = 1'b1;
                    txBit_d    = acc_addr[0];
                end else begin
                    txErr_d = 1'b1;
                end
            end
        end else if (symCnt_q != SYM_LAST) begin
            symCnt_d = symCnt_q + SCW'(1);
        end else begin
            // Last clock of a symbol: decide what goes on air for the next one.
            symCnt_d = '0;
            symIdx_d = symIdx_q + 9'd1;
            symStb_d = 1'b1;
            case (state_q)
                S_PRE: begin
                    if (symIdx_q == 9'd7) begin
                        state_d  = S_AA;
                        symIdx_d = 9'd0;
                        txBit_d  = accAddr_q[0];
                    end else begin
                        txBit_d = ~txBit_q;
                    end
                end
                S_AA: begin
                    if (symIdx_q == 9'd31) begin
                        state_d  = S_PDU;
                        symIdx_d = 9'd0;
                        needByte = 1'b1;
                    end else begin
                        txBit_d = accAddr_q[symIdx_d[4:0]];
                    end
                end
                S_PDU: begin
                    if (symIdx_q == pduLast) begin
                        state_d  = S_CRC;
                        symIdx_d = 9'd0;
                        crcSym   = 1'b1;
                    end else if (symIdx_d[2:0] == 3'd0) begin
                        needByte = 1'b1;
                    end else begin
                        shiftBit = 1'b1;
                    end
                end
                S_CRC: begin
                    if (symIdx_q == 9'd23) begin
                        state_d    = S_IDLE;
                        symIdx_d   = 9'd0;
                        symStb_d   = 1'b0;
                        txActive_d = 1'b0;
                        txBit_d    = 1'b0;
                        txDone_d   = 1'b1;
                    end else begin
                        crcSym = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (needByte && holdFull_q) begin
                rawBit     = hold_q[0];
                shift_d    = {1'b0, hold_q[7:1]};
                holdFull_d = 1'b0;
                emitPdu    = 1'b1;
            end else if (needByte) begin
                // Underrun: the next byte never arrived, abandon the packet.
                state_d    = S_IDLE;
                symIdx_d   = 9'd0;
                symStb_d   = 1'b0;
                txActive_d = 1'b0;
                txBit_d    = 1'b0;
                txErr_d    = 1'b1;
                holdFull_d = 1'b0;
            end else if (shiftBit) begin
                rawBit  = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
                emitPdu = 1'b1;
            end

            if (emitPdu) begin
                crc_d   = crcStep(crc_q, rawBit);
                txBit_d = rawBit ^ whiteBit;
                lfsr_d  = lfsrStep(lfsr_q);
            end

            if (crcSym) begin
                crcSel  = 5'd23 - symIdx_d[4:0];
                txBit_d = crc_q[crcSel] ^ whiteBit;
                lfsr_d  = lfsrStep(lfsr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            symCnt_q   <= '0;
            symIdx_q   <= 9'd0;
            accAddr_q  <= 32'd0;
            pduLen_q   <= 6'd0;
            whitenEn_q <= 1'b0;
            hold_q     <= 8'd0;
            holdFull_q <= 1'b0;
            fetched_q  <= 6'd0;
            shift_q    <= 8'd0;
            crc_q      <= 24'd0;
            lfsr_q     <= 7'd0;
            txBit_q    <= 1'b0;
            symStb_q   <= 1'b0;
            txActive_q <= 1'b0;
            txDone_q   <= 1'b0;
            txErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            symCnt_q   <= symCnt_d;
            symIdx_q   <= symIdx_d;
            accAddr_q  <= accAddr_d;
            pduLen_q   <= pduLen_d;
            whitenEn_q <= whitenEn_d;
            hold_q     <= hold_d;
            holdFull_q <= holdFull_d;
            fetched_q  <= fetched_d;
            shift_q    <= shift_d;
            crc_q      <= crc_d;
            lfsr_q     <= lfsr_d;
            txBit_q    <= txBit_d;
            symStb_q   <= symStb_d;
            txActive_q <= txActive_d;
            txDone_q   <= txDone_d;
            txErr_q    <= txErr_d;
        end
    end
endmodule

// File: tb/tb_ble_packet_tx.sv
// Self-checking bench for ble_packet_tx: a whole-packet symbol model compared every clock,
// plus hand-computed literals for header, whitening, lengths, errors and reset abort.
module tb_ble_packet_tx;
    localparam int CPS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [31:0] acc_addr;
    logic [5:0]  channel;
    logic [5:0]  pdu_len;
    logic        whiten_en;
    logic        tx_bit;
    logic        sym_stb;
    logic        tx_active;
    logic        tx_done;
    logic        tx_err;

    ble_packet_tx_if pduBus();

    ble_packet_tx #(.CLKS_PER_SYM(CPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .acc_addr  (acc_addr),
        .channel   (channel),
        .pdu_len   (pdu_len),
        .whiten_en (whiten_en),
        .pduIf     (pduBus),
        .tx_bit    (tx_bit),
        .sym_stb   (sym_stb),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    int         nCompared;
    int         nMismatched;
    logic [7:0] pduBytes [0:63];
    logic       expBits  [0:511];
    logic       dutSym   [0:511];
    int         expSyms;
    bit         expErrEnd;
    bit         modelOn;
    int         kCnt;
    int         stbCount;
    int         activeCount;
    int         doneCount;
    int         errCount;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Whole-packet symbol list built straight from the on-air format rules.
    task automatic buildModel(input logic [31:0] aa, input logic [5:0] ch, input int len,
                              input logic wen, input int supplied);
        logic [23:0] crc;
        logic        p  [0:6];
        logic        pn [0:6];
        logic        d;
        logic        w;
        logic        fb;
        int          n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            expBits[n] = (i % 2 == 0) ? aa[0] : ~aa[0];
            n++;
        end
        for (int i = 0; i < 32; i++) begin
            expBits[n] = aa[i];
            n++;
        end
        crc  = 24'h555555;
        p[0] = 1'b1;
        for (int j = 0; j < 6; j++) p[j+1] = ch[5-j];
        for (int i = 0; i < 8*len + 24; i++) begin
            if (i < 8*len) begin
                d   = pduBytes[i/8][i%8];
                fb  = crc[23] ^ d;
                crc = {crc[22:0], 1'b0};
                if (fb) crc = crc ^ 24'h00065B;
            end else begin
                d = crc[23 - (i - 8*len)];
            end
            w = p[6];
            for (int j = 1; j < 7; j++) pn[j] = p[j-1];
            pn[0] = p[6];
            pn[4] = p[3] ^ p[6];
            p = pn;
            expBits[n] = d ^ (wen & w);
            n++;
        end
        if (supplied < len) begin
            expSyms   = 40 + 8*supplied;
            expErrEnd = 1'b1;
        end else begin
            expSyms   = n;
            expErrEnd = 1'b0;
        end
    endtask

    // Per-clock comparison of every output against the packet model.
    always @(negedge clk) begin
        if (modelOn) begin
            logic activeExp;
            logic stbExp;
            logic bitExp;
            kCnt++;
            activeExp = (kCnt <= CPS*expSyms);
            stbExp    = activeExp && ((kCnt - 1) % CPS == 0);
            bitExp    = activeExp ? expBits[(kCnt - 1) / CPS] : 1'b0;
            checkOutput("tx_active", {31'd0, tx_active}, {31'd0, activeExp});
            checkOutput("sym_stb", {31'd0, sym_stb}, {31'd0, stbExp});
            checkOutput("tx_bit", {31'd0, tx_bit}, {31'd0, bitExp});
            checkOutput("tx_done", {31'd0, tx_done},
                        {31'd0, (kCnt == CPS*expSyms + 1) && !expErrEnd});
            checkOutput("tx_err", {31'd0, tx_err},
                        {31'd0, (kCnt == CPS*expSyms + 1) && expErrEnd});
            if (sym_stb === 1'b1) begin
                if (stbCount < 512) dutSym[stbCount] = tx_bit;
                stbCount++;
            end
            if (tx_active === 1'b1) activeCount++;
            if (tx_done === 1'b1) doneCount++;
            if (tx_err === 1'b1) errCount++;
            if (kCnt >= CPS*expSyms + 3) modelOn = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [31:0] aa, input logic [5:0] ch, input int len,
                                 input logic wen, input int supplied, input int abortAt,
                                 input int busyStartAt);
        int idx;
        int budget;
        buildModel(aa, ch, len, wen, supplied);
        @(negedge clk);
        acc_addr  = aa;
        channel   = ch;
        pdu_len   = 6'(len);
        whiten_en = wen;
        tx_start  = 1'b1;
        @(posedge clk);
        #1;
        tx_start    = 1'b0;
        kCnt        = 0;
        stbCount    = 0;
        activeCount = 0;
        doneCount   = 0;
        errCount    = 0;
        modelOn     = 1'b1;
        idx         = 0;
        budget      = CPS*(64 + 8*len) + 64;
        for (int cyc = 1; cyc <= budget && modelOn; cyc++) begin
            @(negedge clk);
            if (idx < supplied && idx < len) begin
                pduBus.pdu_valid = 1'b1;
                pduBus.pdu_data  = pduBytes[idx];
            end else begin
                pduBus.pdu_valid = 1'b0;
                pduBus.pdu_data  = 8'h00;
            end
            if (pduBus.pdu_valid && pduBus.pdu_ready) idx++;
            if (cyc == busyStartAt) begin
                pdu_len  = 6'd1;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            if (cyc == abortAt) begin
                #1;
                modelOn = 1'b0;
                rst     = 1'b0;
                #1;
                checkOutput("abort tx_active", {31'd0, tx_active}, 32'd0);
                checkOutput("abort sym_stb", {31'd0, sym_stb}, 32'd0);
                checkOutput("abort tx_bit", {31'd0, tx_bit}, 32'd0);
                checkOutput("abort tx_done", {31'd0, tx_done}, 32'd0);
                checkOutput("abort tx_err", {31'd0, tx_err}, 32'd0);
                checkOutput("abort pdu_ready", {31'd0, pduBus.pdu_ready}, 32'd0);
                pduBus.pdu_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("abort no done", {31'd0, tx_done}, 32'd0);
                end
                rst = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("abort stays idle", {31'd0, tx_active | tx_done | tx_err}, 32'd0);
                end
            end
        end
        pduBus.pdu_valid = 1'b0;
        tx_start         = 1'b0;
        if (modelOn) begin
            checkOutput("packet timeout", 32'd1, 32'd0);
            modelOn = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic rejectStart(input int len);
        @(negedge clk);
        pdu_len  = 6'(len);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        checkOutput("reject tx_err", {31'd0, tx_err}, 32'd1);
        checkOutput("reject tx_active", {31'd0, tx_active}, 32'd0);
        @(negedge clk);
        checkOutput("reject err single", {31'd0, tx_err}, 32'd0);
        checkOutput("reject still idle", {31'd0, tx_active}, 32'd0);
        checkOutput("reject no strobe", {31'd0, sym_stb}, 32'd0);
    endtask

    function automatic logic [7:0] dutByteAt(input int base);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = dutSym[base + j];
        return v;
    endfunction

    initial begin
        logic [15:0] hdr;
        rst              = 1'b1;
        tx_start         = 1'b0;
        acc_addr         = 32'd0;
        channel          = 6'd0;
        pdu_len          = 6'd0;
        whiten_en        = 1'b0;
        pduBus.pdu_valid = 1'b0;
        pduBus.pdu_data  = 8'h00;
        modelOn          = 1'b0;
        nCompared        = 0;
        nMismatched      = 0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset tx_active", {31'd0, tx_active}, 32'd0);
        checkOutput("reset sym_stb", {31'd0, sym_stb}, 32'd0);
        checkOutput("reset tx_bit", {31'd0, tx_bit}, 32'd0);
        checkOutput("reset tx_done", {31'd0, tx_done}, 32'd0);
        checkOutput("reset tx_err", {31'd0, tx_err}, 32'd0);
        checkOutput("reset pdu_ready", {31'd0, pduBus.pdu_ready}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] header and minimum length packet");
        pduBytes[0] = 8'h02;
        pduBytes[1] = 8'h00;
        applyStimulus(32'h6B7D9171, 6'd37, 2, 1'b1, 2, 0, 0);
        for (int i = 0; i < 16; i++) hdr[i] = dutSym[i];
        checkOutput("header bits", {16'd0, hdr}, 32'h7155);
        checkOutput("len2 sym_stb count", stbCount, 80);
        checkOutput("len2 active cycles", activeCount, 1280);
        checkOutput("len2 tx_done count", doneCount, 1);

        $display("[TB] whitening on and off");
        pduBytes[0] = 8'h00;
        pduBytes[1] = 8'h5A;
        applyStimulus(32'h8E89BED6, 6'd37, 2, 1'b1, 2, 0, 0);
        checkOutput("whitened zero byte", {24'd0, dutByteAt(40)}, 32'h8D);
        applyStimulus(32'h8E89BED6, 6'd37, 2, 1'b0, 2, 0, 0);
        checkOutput("plain zero byte", {24'd0, dutByteAt(40)}, 32'h00);

        $display("[TB] maximum length with an ignored start mid-packet");
        for (int i = 0; i < 39; i++) pduBytes[i] = 8'(i*7 + 3);
        applyStimulus(32'h50654ADE, 6'd5, 39, 1'b1, 39, 0, 700);
        checkOutput("len39 sym_stb count", stbCount, 376);
        checkOutput("len39 tx_err count", errCount, 0);

        $display("[TB] advertising style PDU");
        pduBytes[0] = 8'h02;
        pduBytes[1] = 8'h06;
        for (int i = 2; i < 8; i++) pduBytes[i] = 8'(8'h11 * (i - 1));
        applyStimulus(32'h6B7D9171, 6'd37, 8, 1'b1, 8, 0, 0);
        checkOutput("len8 tx_done count", doneCount, 1);

        $display("[TB] rejected starts");
        rejectStart(1);
        rejectStart(40);
        rejectStart(0);

        $display("[TB] underrun cases");
        applyStimulus(32'h6B7D9171, 6'd12, 4, 1'b1, 0, 0, 0);
        checkOutput("underrun0 sym_stb count", stbCount, 40);
        checkOutput("underrun0 tx_done count", doneCount, 0);
        checkOutput("underrun0 tx_err count", errCount, 1);
        applyStimulus(32'h6B7D9171, 6'd12, 4, 1'b1, 2, 0, 0);
        checkOutput("underrun2 sym_stb count", stbCount, 56);
        checkOutput("underrun2 tx_done count", doneCount, 0);

        $display("[TB] reset during access address then fresh packet");
        pduBytes[0] = 8'hC3;
        pduBytes[1] = 8'h01;
        pduBytes[2] = 8'hFF;
        applyStimulus(32'hA5F00F5A, 6'd20, 3, 1'b1, 3, 300, 0);
        applyStimulus(32'hA5F00F5A, 6'd20, 3, 1'b1, 3, 0, 0);
        checkOutput("post-reset tx_done count", doneCount, 1);
        checkOutput("post-reset sym_stb count", stbCount, 88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
